// File: rtl/piso_pkg.sv
// piso_pkg: state encoding and sizing helper shared by piso_sched and rr_arbiter.
// Optional feature macro: PISO_SCHED_PARITY_EN (adds the PARITY state).
package piso_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
`ifdef PISO_SCHED_PARITY_EN
        StParity = 2'd2,
`endif
        StGap    = 2'd3
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter. The search starts one past the last granted
// requester and wraps; the pointer moves only when the caller signals advance.
module rr_arbiter
    import piso_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic                             advance,
    output logic [NUM_REQ-1:0]               grant,
    output logic [id_width(NUM_REQ)-1:0]     grant_idx
);

    localparam int unsigned ID_W = id_width(NUM_REQ);

    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] cand;
    logic            found;

    // Pick the first asserted request at offsets 1..NUM_REQ from last_q.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(last_q) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pointer resets to the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= ID_W'(NUM_REQ - 1);
        end else if (advance) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/piso_sched.sv
// piso_sched: round-robin scheduler feeding a shared MSB-first serializer.
// Words are taken from NUM_REQ requesters, shifted out one bit per ready
// handshake, and followed by GAP_CYCLES idle cycles.
// Optional feature macro: PISO_SCHED_PARITY_EN appends an even-parity bit.
module piso_sched
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 42,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GAP_CYCLES = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         ser_data,
    output logic                         ser_valid,
    input  logic                         ser_ready,
    output logic                         ser_first,
    output logic                         ser_last,
    output logic [id_width(NUM_REQ)-1:0] ser_id,
    output logic                         busy
);

    localparam int unsigned ID_W  = id_width(NUM_REQ);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam state_t      POST_FRAME = (GAP_CYCLES > 0) ? StGap : StIdle;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
`ifdef PISO_SCHED_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [WIDTH-1:0]   word;
    logic               handshake;
    logic               last_bit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (handshake),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Select the winning requester's word with constant part-selects.
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                word = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ser_id = id_q;

    // Next-state and output decode; reset masks every handshake and output.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        gap_d     = gap_q;
`ifdef PISO_SCHED_PARITY_EN
        parity_d  = parity_q;
`endif
        req_ready = '0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b1;
        handshake = 1'b0;
        last_bit  = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy      = 1'b0;
                req_ready = grant;
                handshake = |(req_valid & grant);
                gap_d     = '0;
                if (handshake) begin
                    shreg_d  = word;
                    id_d     = grant_idx;
                    cnt_d    = '0;
`ifdef PISO_SCHED_PARITY_EN
                    parity_d = ^word;
`endif
                    state_d  = StShift;
                end
            end
            StShift: begin
                ser_valid = 1'b1;
                ser_data  = shreg_q[WIDTH-1];
                ser_first = (cnt_q == '0);
                last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
`ifndef PISO_SCHED_PARITY_EN
                ser_last  = last_bit;
`endif
                if (ser_ready) begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        cnt_d   = '0;
`ifdef PISO_SCHED_PARITY_EN
                        state_d = StParity;
`else
                        state_d = POST_FRAME;
`endif
                    end
                end
            end
`ifdef PISO_SCHED_PARITY_EN
            StParity: begin
                ser_valid = 1'b1;
                ser_data  = parity_q;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    state_d = POST_FRAME;
                end
            end
`endif
            StGap: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rst) begin
            req_ready = '0;
            ser_valid = 1'b0;
            ser_data  = 1'b0;
            ser_first = 1'b0;
            ser_last  = 1'b0;
            busy      = 1'b0;
            handshake = 1'b0;
        end
    end

    // State register; reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            gap_q    <= '0;
`ifdef PISO_SCHED_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            gap_q    <= gap_d;
`ifdef PISO_SCHED_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_sched.sv
// tb_piso_sched: directed bench for piso_sched with a word scoreboard.
// Honours PISO_SCHED_PARITY_EN by expecting one extra parity bit per frame.
module tb_piso_sched;

    localparam int W = 42;
    localparam int N = 4;
`ifdef PISO_SCHED_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT (default gap)
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           ser_data, ser_valid, ser_ready, ser_first, ser_last, busy;
    logic [1:0]     ser_id;
    logic [W-1:0]   dwords [N];

    // Zero-gap DUT
    logic [N-1:0]   g_valid;
    logic [N*W-1:0] g_data;
    logic [N-1:0]   g_ready;
    logic           g_ser_data, g_ser_valid, g_ser_first, g_ser_last, g_busy;
    logic           g_rdy;
    logic [1:0]     g_ser_id;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = dwords[i];
    end

    piso_sched #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .ser_id    (ser_id),
        .busy      (busy)
    );

    piso_sched #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(0)) dut_gap0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (g_valid),
        .req_data  (g_data),
        .req_ready (g_ready),
        .ser_data  (g_ser_data),
        .ser_valid (g_ser_valid),
        .ser_ready (g_rdy),
        .ser_first (g_ser_first),
        .ser_last  (g_ser_last),
        .ser_id    (g_ser_id),
        .busy      (g_busy)
    );

    typedef struct {
        int           id;
        logic [W-1:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   frames_done = 0;
    int   m_last = N - 1;
    bit   rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int off = 1; off <= N; off++) begin
            if (v[(last + off) % N]) return (last + off) % N;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Sink: rebuild frames bit by bit and compare them against the scoreboard.
    int          mbits = 0;
    int          mid = 0;
    logic [63:0] acc = '0;
    logic [63:0] ef;
    exp_t        e;
    always @(negedge clk) begin
        if (rst) begin
            mbits = 0;
        end else if (ser_valid && ser_ready) begin
            if (mbits == 0) begin
                acc = '0;
                mid = int'(ser_id);
            end
            chk("ser_first", 64'(ser_first), 64'(mbits == 0));
            chk("ser_last", 64'(ser_last), 64'(mbits == FRAME - 1));
            chk("ser_id_stable", 64'(ser_id), 64'(mid));
            acc = {acc[62:0], ser_data};
            mbits++;
            if (mbits == FRAME) begin
                mbits = 0;
                frames_done++;
                chk("frame_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (PAR != 0) ef = 64'({e.word, ^e.word});
                    else ef = 64'(e.word);
                    chk("frame_id", 64'(mid), 64'(e.id));
                    chk("frame_word", acc, ef);
                end
            end
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ser_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (!busy) return;
            tick();
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic wait_last();
        for (int i = 0; i < 300; i++) begin
            if (ser_valid && ser_last && ser_ready) return;
            tick();
        end
        chk("last_timeout", 64'(ser_last), 64'd1);
    endtask

    // Offer mask v, predict the winner, check the grant and queue the word.
    task automatic serve(input logic [N-1:0] v);
        int           win;
        logic [N-1:0] oh;
        req_valid = v;
        #1;
        wait_idle();
        win = rr_pick(v, m_last);
        oh = '0;
        oh[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(oh));
        exp_q.push_back('{id: win, word: dwords[win]});
        tick();
        m_last = win;
        dwords[win] = rand_word();
    endtask

    logic [W-1:0] w1;
    int           fr;
    bit           seen;

    initial begin
        req_valid = '0;
        ser_ready = 1'b1;
        g_valid   = '0;
        g_rdy     = 1'b1;
        g_data    = {4{42'h155_0F0F_3C3C}};
        for (int i = 0; i < N; i++) dwords[i] = rand_word();

        // Reset: outputs held low even with all requests pending.
        rst = 1'b1;
        req_valid = 4'hF;
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(ser_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        req_valid = '0;
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_valid", 64'(ser_valid), 64'd0);
        chk("post_rst_first", 64'(ser_first), 64'd0);
        chk("post_rst_last", 64'(ser_last), 64'd0);
        chk("post_rst_id", 64'(ser_id), 64'd0);

        // Single word from requester 2, with a short stall on the first bit.
        w1 = 42'h2AA_5555_AAAA;
        dwords[2] = w1;
        m_last = N - 1;
        serve(4'b0100);
        chk("shift_ready_zero", 64'(req_ready), 64'd0);
        chk("shift_valid", 64'(ser_valid), 64'd1);
        chk("shift_first", 64'(ser_first), 64'd1);
        chk("shift_id", 64'(ser_id), 64'd2);
        chk("shift_busy", 64'(busy), 64'd1);
        req_valid = '0;
        ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", 64'(ser_data), 64'(w1[W-1]));
            chk("stall_first", 64'(ser_first), 64'd1);
            chk("stall_id", 64'(ser_id), 64'd2);
        end
        ser_ready = 1'b1;
        wait_last();
        tick();
        chk("gap1_busy", 64'(busy), 64'd1);
        chk("gap1_valid", 64'(ser_valid), 64'd0);
        tick();
        chk("gap2_valid", 64'(ser_valid), 64'd0);
        tick();
        chk("gap3_busy", 64'(busy), 64'd1);
        chk("gap3_valid", 64'(ser_valid), 64'd0);
        tick();
        chk("gap_end_busy", 64'(busy), 64'd0);
        chk("frames_t1", 64'(frames_done), 64'd1);

        // Word 1: LSB is 1, and so is its even parity.
        dwords[0] = 42'h1;
        serve(4'b0001);
        req_valid = '0;
        wait_last();
        chk("final_bit", 64'(ser_data), 64'd1);
        wait_idle();

        // All four valid after reset: grant order 0,1,2,3,0.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_last = N - 1;
        for (int k = 0; k < 5; k++) begin
            serve(4'hF);
            chk("rr_order", 64'(m_last), 64'(k % N));
        end
        req_valid = '0;
        wait_idle();
        chk("rr_drained", 64'(exp_q.size()), 64'd0);

        // Random backpressure, 100 words per requester.
        rand_ready = 1'b1;
        for (int k = 0; k < 4 * 100; k++) serve(4'hF);
        req_valid = '0;
        wait_idle();
        rand_ready = 1'b0;
        tick();
        ser_ready = 1'b1;
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a word.
        serve(4'b0010);
        req_valid = '0;
        repeat (20) tick();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(ser_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("after_rst_valid", 64'(ser_valid), 64'd0);
        chk("after_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        m_last = N - 1;
        fr = frames_done;
        serve(4'b0011);
        req_valid = '0;
        wait_idle();
        chk("after_rst_frames", 64'(frames_done), 64'(fr + 1));
        chk("after_rst_drained", 64'(exp_q.size()), 64'd0);

        // Zero-gap instance: exactly one idle cycle between frames.
        g_valid = 4'b0011;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (g_ser_valid && g_ser_last) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("g_last_seen", 64'(seen), 64'd1);
        tick();
        chk("g_idle_valid", 64'(g_ser_valid), 64'd0);
        chk("g_idle_busy", 64'(g_busy), 64'd0);
        chk("g_idle_grant", 64'(g_ready), 64'b0010);
        tick();
        chk("g_next_valid", 64'(g_ser_valid), 64'd1);
        chk("g_next_first", 64'(g_ser_first), 64'd1);
        chk("g_next_id", 64'(g_ser_id), 64'd1);
        g_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
